// File: rtl/cube_pkg.sv
// Shared types and constants for the cube vertex transform datapath.
// Fixed-point format is Q6.2 by default: 1.0 is ONE_FX.
package cube_pkg;

  localparam int SIZE         = 3;
  localparam int IN_BITS      = 8;
  localparam int IN_FRAC_BITS = 2;
  localparam int CUBE_HALF    = 4;
  localparam int ONE_FX       = 1 << IN_FRAC_BITS;
  localparam int NUM_VERTS    = 2 ** SIZE;

  typedef logic signed [IN_BITS-1:0] fixed_t;
  typedef fixed_t [SIZE-1:0]         vec_t;
  typedef vec_t [SIZE-1:0]           mat_t;

  typedef enum logic [1:0] {IDLE, MUL, SUM, HOLD} state_t;

endpackage

// File: rtl/fixed_round_sat.sv
// One output row: sums SIZE signed products, arithmetic-shifts out the
// fractional bits (floor) and saturates to the signed IN_BITS range.
module fixed_round_sat #(
  parameter int SIZE         = 3,
  parameter int IN_BITS      = 8,
  parameter int IN_FRAC_BITS = 2
) (
  input  logic [SIZE-1:0][2*IN_BITS-1:0] i_prod,
  output logic [IN_BITS-1:0]             o_val
);

  localparam int ACC_W = 2*IN_BITS + $clog2(SIZE);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (IN_BITS-1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - 1;

  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shift;

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < SIZE; c++) begin
      w_sum = w_sum + ACC_W'($signed(i_prod[c]));
    end
    w_shift = w_sum >>> IN_FRAC_BITS;
    if (w_shift > MAX_V) begin
      o_val = IN_BITS'(MAX_V);
    end else if (w_shift < MIN_V) begin
      o_val = IN_BITS'(MIN_V);
    end else begin
      o_val = IN_BITS'(w_shift);
    end
  end

endmodule

// File: rtl/vertex_transform.sv
// Latches one rotation matrix, applies it to the 8 cube corners and streams
// the transformed vertices out over valid/ready, 3 cycles per vertex.
module vertex_transform #(
  parameter int SIZE         = cube_pkg::SIZE,
  parameter int IN_BITS      = cube_pkg::IN_BITS,
  parameter int IN_FRAC_BITS = cube_pkg::IN_FRAC_BITS,
  parameter int CUBE_HALF    = cube_pkg::CUBE_HALF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0] mat_in,
  input  logic                                 mat_valid,
  output logic                                 mat_ready,
  output logic [SIZE-1:0][IN_BITS-1:0]         out_vert,
  output logic [2:0]                           out_idx,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy
);
  import cube_pkg::*;

  localparam int NUM_V = 2 ** SIZE;
  localparam int C_INT = CUBE_HALF << IN_FRAC_BITS;
  localparam logic [IN_BITS-1:0] C_POS = IN_BITS'(C_INT);
  localparam logic [IN_BITS-1:0] C_NEG = IN_BITS'(-C_INT);
  localparam logic [2:0] LAST_IDX = 3'(NUM_V - 1);

  generate
    if (SIZE != 3) begin : g_bad_size
      $error("vertex_transform: corner ROM requires SIZE == 3");
    end
  endgenerate

  state_t r_state;
  state_t w_state_next;

  logic [SIZE-1:0][SIZE-1:0][IN_BITS-1:0]   r_mat;
  logic [SIZE-1:0][SIZE-1:0][2*IN_BITS-1:0] r_prod;
  logic [SIZE-1:0][SIZE-1:0][2*IN_BITS-1:0] w_prod;
  logic [SIZE-1:0][IN_BITS-1:0]             w_vert;
  logic [SIZE-1:0][IN_BITS-1:0]             w_row;
  logic [SIZE-1:0][IN_BITS-1:0]             r_out_vert;
  logic [2:0]                               r_idx;
  logic                                     r_out_valid;
  logic                                     w_accept;
  logic                                     w_hs;

  assign mat_ready = (r_state == IDLE);
  assign busy      = ~mat_ready;
  assign w_accept  = mat_valid & mat_ready;
  assign w_hs      = r_out_valid & out_ready;
  assign out_vert  = r_out_vert;
  assign out_idx   = r_idx;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_valid & (r_idx == LAST_IDX);

  // Corner ROM: bit k of the vertex index picks the sign of coordinate k.
  genvar gi, gj;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_row
      assign w_vert[gi] = r_idx[gi] ? C_POS : C_NEG;
      for (gj = 0; gj < SIZE; gj++) begin : g_col
        assign w_prod[gi][gj] = $signed(r_mat[gi][gj]) * $signed(w_vert[gj]);
      end
      fixed_round_sat #(
        .SIZE(SIZE), .IN_BITS(IN_BITS), .IN_FRAC_BITS(IN_FRAC_BITS)
      ) u_row (
        .i_prod(r_prod[gi]),
        .o_val (w_row[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = MUL;
      MUL:     w_state_next = SUM;
      SUM:     w_state_next = HOLD;
      HOLD:    if (w_hs) w_state_next = (r_idx == LAST_IDX) ? IDLE : MUL;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mat       <= '0;
      r_prod      <= '0;
      r_out_vert  <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_mat <= mat_in;
          r_idx <= '0;
        end
        MUL:  r_prod <= w_prod;
        SUM: begin
          r_out_vert  <= w_row;
          r_out_valid <= 1'b1;
        end
        HOLD: if (w_hs) begin
          r_out_valid <= 1'b0;
          // idx stays at the last vertex so out_idx is stable until the next accept
          if (r_idx != LAST_IDX) r_idx <= r_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_transform.sv
// Scoreboard bench for vertex_transform: stimulus pushes model results,
// an independent monitor pops and compares on every output handshake.
module tb_vertex_transform;

  typedef struct packed {
    logic [2:0]      idx;
    logic [2:0][7:0] v;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2:0][2:0][7:0] mat_in = '0;
  logic                 mat_valid = 1'b0;
  logic                 mat_ready;
  logic [2:0][7:0]      out_vert;
  logic [2:0]           out_idx;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   stall_cnt = 0;
  int   stall_seen = 0;
  int   m_cur[3][3];
  exp_t sb_q[$];

  vertex_transform dut (
    .clk(clk), .rst(rst), .mat_in(mat_in), .mat_valid(mat_valid),
    .mat_ready(mat_ready), .out_vert(out_vert), .out_idx(out_idx),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // out_ready: 0 = always ready, 1 = random, 2 = stall 5 cycles at idx 3
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) begin
      out_ready = ($urandom_range(0, 3) != 0);
      stall_cnt = 0;
    end else if (rdy_mode == 2 && out_valid && out_idx == 3'd3 && stall_cnt < 5) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else begin
      out_ready = 1'b1;
      if (rdy_mode != 2) stall_cnt = 0;
    end
  end

  // Reference: each corner is (+/-16) per axis, rows dotted, floor /4, clamp.
  function automatic logic [2:0][7:0] model_vertex(int idx);
    logic [2:0][7:0] res;
    for (int r = 0; r < 3; r++) begin
      int s = 0;
      int q;
      for (int c = 0; c < 3; c++) begin
        s += m_cur[r][c] * ((((idx >> c) & 1) != 0) ? 16 : -16);
      end
      q = (s - (((s % 4) + 4) % 4)) / 4;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      res[r] = 8'(q);
    end
    return res;
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.idx = 3'(i);
      e.v   = model_vertex(i);
      sb_q.push_back(e);
    end
  endtask

  task automatic load_mat_in();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mat_in[r][c] = 8'(m_cur[r][c]);
  endtask

  task automatic set_diag(input int d);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m_cur[r][c] = (r == c) ? d : 0;
  endtask

  task automatic set_random();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m_cur[r][c] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic check(input string name, input logic ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic send_matrix();
    int t = 0;
    @(negedge clk);
    while (!mat_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("send_timeout", mat_ready, 0, 1);
    load_mat_in();
    mat_valid = 1'b1;
    push_expected();
    $display("matrix issued at cycle %0d: row0=(%0d,%0d,%0d)", cyc,
             m_cur[0][0], m_cur[0][1], m_cur[0][2]);
    @(negedge clk);
    mat_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || !mat_ready) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", sb_q.size() == 0 && mat_ready, sb_q.size(), 0);
  endtask

  // Monitor: compares on handshake and checks outputs hold while stalled.
  initial begin
    logic            prev_stall = 1'b0;
    logic [2:0][7:0] prev_vert = '0;
    logic [2:0]      prev_idx = '0;
    exp_t            e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", out_valid, int'(out_valid), 1);
          check("stall_vert", out_vert == prev_vert, int'(out_vert), int'(prev_vert));
          check("stall_idx", out_idx == prev_idx, int'(out_idx), int'(prev_idx));
        end
        if (out_valid && !out_ready && out_idx == 3'd3 && rdy_mode == 2) stall_seen++;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_output", 1'b0, int'(out_idx), -1);
          end else begin
            e = sb_q.pop_front();
            $display("vertex idx=%0d out=(%0d,%0d,%0d) exp=(%0d,%0d,%0d) last=%0d",
                     out_idx, $signed(out_vert[0]), $signed(out_vert[1]), $signed(out_vert[2]),
                     $signed(e.v[0]), $signed(e.v[1]), $signed(e.v[2]), out_last);
            check("vertex_idx", out_idx == e.idx, int'(out_idx), int'(e.idx));
            check("vertex_value", out_vert == e.v, int'(out_vert), int'(e.v));
            check("out_last", out_last == (e.idx == 3'd7), int'(out_last), int'(e.idx == 3'd7));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_vert  = out_vert;
        prev_idx   = out_idx;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int t1;
    int t2;

    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    check("reset_out_vert", out_vert == '0, int'(out_vert), 0);
    check("reset_out_idx", out_idx == '0, int'(out_idx), 0);
    check("reset_out_last", out_last == 1'b0, int'(out_last), 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_mat_ready", mat_ready == 1'b1, int'(mat_ready), 1);
    check("reset_busy", busy == 1'b0, int'(busy), 0);

    // Directed matrices
    rdy_mode = 0;
    set_diag(4);   send_matrix();
    @(negedge clk);
    check("busy_running", busy == 1'b1, int'(busy), 1);
    drain();
    m_cur = '{'{0, -4, 0}, '{4, 0, 0}, '{0, 0, 4}};
    send_matrix(); drain();
    set_diag(127); send_matrix(); drain();
    set_diag(8);   send_matrix(); drain();
    set_diag(-128); send_matrix(); drain();

    // Backpressure at idx 3
    rdy_mode = 2;
    stall_seen = 0;
    set_random(); send_matrix(); drain();
    check("stall_cycles", stall_seen == 5, stall_seen, 5);
    rdy_mode = 0;

    // Random matrices under random backpressure
    rdy_mode = 1;
    for (int n = 0; n < 15; n++) begin
      set_random();
      send_matrix();
    end
    drain();
    rdy_mode = 0;

    // mat_valid held through a run: second matrix waits for IDLE
    @(negedge clk);
    set_random(); load_mat_in(); mat_valid = 1'b1;
    push_expected();
    t1 = cyc;
    @(negedge clk);
    set_random(); load_mat_in();
    t = 0;
    while (!mat_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("held_accept_timeout", mat_ready, 0, 1);
    push_expected();
    t2 = cyc;
    $display("held-valid accepts at cycles %0d and %0d", t1, t2);
    check("accept_to_accept", (t2 - t1) == 25, t2 - t1, 25);
    @(negedge clk);
    mat_valid = 1'b0;
    drain();

    // Reset in HOLD at idx 4
    set_random(); send_matrix();
    t = 0;
    while (!(out_valid && out_idx == 3'd4) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("reach_idx4", out_valid && out_idx == 3'd4, int'(out_idx), 4);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
    check("midrst_out_idx", out_idx == '0, int'(out_idx), 0);
    check("midrst_out_last", out_last == 1'b0, int'(out_last), 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_mat_ready", mat_ready == 1'b1, int'(mat_ready), 1);
    set_random(); send_matrix(); drain();
    repeat (4) @(negedge clk);
    check("no_extra_output", out_valid == 1'b0, int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
